// File: rtl/dpic_mem_arbiter_if.sv
// Bus bundle between the IF/LSU requesters, dpic_mem_arbiter and the DPI-C memory port.
// slave  : the arbiter side.
// master : the core + memory environment side.
interface dpic_mem_arbiter_if;

    localparam int unsigned ADDR_W = 64;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned MASK_W = 8;

    // Instruction-fetch read port
    logic              if_req_valid;
    logic              if_req_ready;
    logic [ADDR_W-1:0] if_req_addr;
    logic              if_resp_valid;
    logic              if_resp_ready;
    logic [DATA_W-1:0] if_resp_rdata;

    // Load/store read/write port
    logic              lsu_req_valid;
    logic              lsu_req_ready;
    logic [ADDR_W-1:0] lsu_req_addr;
    logic              lsu_req_wen;
    logic [DATA_W-1:0] lsu_req_wdata;
    logic [MASK_W-1:0] lsu_req_wmask;
    logic              lsu_resp_valid;
    logic              lsu_resp_ready;
    logic [DATA_W-1:0] lsu_resp_rdata;
    logic              lsu_resp_err;

    // DPI-C memory read port
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic [DATA_W-1:0] mem_rd_data;

    // DPI-C memory write port
    logic              mem_we_en;
    logic [ADDR_W-1:0] mem_we_addr;
    logic [DATA_W-1:0] mem_we_data;
    logic [MASK_W-1:0] mem_we_mask;

    modport slave (
        input  if_req_valid,
        input  if_req_addr,
        output if_req_ready,
        output if_resp_valid,
        input  if_resp_ready,
        output if_resp_rdata,
        input  lsu_req_valid,
        input  lsu_req_addr,
        input  lsu_req_wen,
        input  lsu_req_wdata,
        input  lsu_req_wmask,
        output lsu_req_ready,
        output lsu_resp_valid,
        input  lsu_resp_ready,
        output lsu_resp_rdata,
        output lsu_resp_err,
        output mem_rd_en,
        output mem_rd_addr,
        input  mem_rd_data,
        output mem_we_en,
        output mem_we_addr,
        output mem_we_data,
        output mem_we_mask
    );

    modport master (
        output if_req_valid,
        output if_req_addr,
        input  if_req_ready,
        input  if_resp_valid,
        output if_resp_ready,
        input  if_resp_rdata,
        output lsu_req_valid,
        output lsu_req_addr,
        output lsu_req_wen,
        output lsu_req_wdata,
        output lsu_req_wmask,
        input  lsu_req_ready,
        input  lsu_resp_valid,
        output lsu_resp_ready,
        input  lsu_resp_rdata,
        input  lsu_resp_err,
        input  mem_rd_en,
        input  mem_rd_addr,
        output mem_rd_data,
        input  mem_we_en,
        input  mem_we_addr,
        input  mem_we_data,
        input  mem_we_mask
    );

endinterface

// File: rtl/dpic_mem_arbiter.sv
// Two-requester (IF read / LSU read-write) arbiter and sequencer in front of the
// single DPI-C memory port. Emulates LATENCY wait cycles per access and issues
// each write as a single-cycle enable pulse with stable address/data/mask.
// Optional feature macro: DPIC_ARB_FIXED_PRIO_EN (LSU always wins a tie);
// when undefined, ties are resolved by a round-robin pointer.
module dpic_mem_arbiter #(
    parameter int unsigned LATENCY = 2
) (
    input  logic              clock,
    input  logic              reset,
    dpic_mem_arbiter_if.slave bus
);

    localparam int unsigned CNT_W  = 4;
    localparam int unsigned ADDR_W = 64;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned MASK_W = 8;

    // Counter start value; zero means the access happens in the first BUSY cycle.
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

    localparam logic PORT_IF  = 1'b0;
    localparam logic PORT_LSU = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;

    // Latched transaction
    logic              port_q;
    logic [ADDR_W-1:0] addr_q;
    logic              wen_q;
    logic [DATA_W-1:0] wdata_q;
    logic [MASK_W-1:0] wmask_q;
    logic              mask_ok_q;

    // Registered outputs
    logic              rd_en_q;
    logic              we_en_q;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;
    logic              if_valid_q;
    logic              lsu_valid_q;

`ifndef DPIC_ARB_FIXED_PRIO_EN
    logic              ptr_q;
`endif

    logic              grant_if_c;
    logic              grant_lsu_c;
    logic              accept_c;
    logic              acc_wen_c;
    logic              acc_mask_ok_c;
    logic              resp_ready_c;

    // Only byte, half, word and double-word masks are accepted by the memory.
    function automatic logic mask_legal(input logic [MASK_W-1:0] m);
        case (m)
            8'h01, 8'h03, 8'h0F, 8'hFF: return 1'b1;
            default:                    return 1'b0;
        endcase
    endfunction

    // Grant decision; only meaningful in IDLE, and never grants both ports.
    always_comb begin
        grant_if_c  = 1'b0;
        grant_lsu_c = 1'b0;
        if (state == IDLE) begin
`ifdef DPIC_ARB_FIXED_PRIO_EN
            if (bus.lsu_req_valid) begin
                grant_lsu_c = 1'b1;
            end else if (bus.if_req_valid) begin
                grant_if_c = 1'b1;
            end
`else
            if (bus.if_req_valid && bus.lsu_req_valid) begin
                grant_lsu_c = (ptr_q == PORT_LSU);
                grant_if_c  = (ptr_q == PORT_IF);
            end else if (bus.if_req_valid) begin
                grant_if_c = 1'b1;
            end else if (bus.lsu_req_valid) begin
                grant_lsu_c = 1'b1;
            end
`endif
        end
    end

    // Accept-side qualifiers; IF requests are always reads.
    always_comb begin
        accept_c      = grant_if_c || grant_lsu_c;
        acc_wen_c     = grant_lsu_c && bus.lsu_req_wen;
        acc_mask_ok_c = !acc_wen_c || mask_legal(bus.lsu_req_wmask);
        resp_ready_c  = (port_q == PORT_LSU) ? bus.lsu_resp_ready : bus.if_resp_ready;
    end

    // Sequencer: accept, count down the latency, access memory, hold the response.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            cnt         <= '0;
            port_q      <= PORT_IF;
            addr_q      <= '0;
            wen_q       <= 1'b0;
            wdata_q     <= '0;
            wmask_q     <= '0;
            mask_ok_q   <= 1'b0;
            rd_en_q     <= 1'b0;
            we_en_q     <= 1'b0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            if_valid_q  <= 1'b0;
            lsu_valid_q <= 1'b0;
`ifndef DPIC_ARB_FIXED_PRIO_EN
            ptr_q       <= PORT_IF;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept_c) begin
                        state     <= BUSY;
                        cnt       <= CNT_INIT;
                        port_q    <= grant_lsu_c ? PORT_LSU : PORT_IF;
                        addr_q    <= grant_lsu_c ? bus.lsu_req_addr : bus.if_req_addr;
                        wen_q     <= acc_wen_c;
                        wdata_q   <= grant_lsu_c ? bus.lsu_req_wdata : '0;
                        wmask_q   <= grant_lsu_c ? bus.lsu_req_wmask : '0;
                        mask_ok_q <= acc_mask_ok_c;
                        // With a zero count the access cycle is the very next one.
                        rd_en_q   <= (CNT_INIT == '0) && !acc_wen_c;
                        we_en_q   <= (CNT_INIT == '0) && acc_wen_c && acc_mask_ok_c;
`ifndef DPIC_ARB_FIXED_PRIO_EN
                        ptr_q     <= grant_lsu_c ? PORT_IF : PORT_LSU;
`endif
                    end
                end
                BUSY: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                        // Arm the enables so they are high exactly in the count-zero cycle.
                        if (cnt == CNT_W'(1)) begin
                            rd_en_q <= !wen_q;
                            we_en_q <= wen_q && mask_ok_q;
                        end
                    end else begin
                        rd_en_q <= 1'b0;
                        we_en_q <= 1'b0;
                        rdata_q <= wen_q ? '0 : bus.mem_rd_data;
                        err_q   <= wen_q && !mask_ok_q;
                        if (port_q == PORT_LSU) begin
                            lsu_valid_q <= 1'b1;
                        end else begin
                            if_valid_q <= 1'b1;
                        end
                        state <= RESP;
                    end
                end
                RESP: begin
                    if (resp_ready_c) begin
                        if_valid_q  <= 1'b0;
                        lsu_valid_q <= 1'b0;
                        err_q       <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Request handshake
    assign bus.if_req_ready   = grant_if_c;
    assign bus.lsu_req_ready  = grant_lsu_c;

    // Responses share one data register; only the owning port's valid is raised.
    assign bus.if_resp_valid  = if_valid_q;
    assign bus.if_resp_rdata  = rdata_q;
    assign bus.lsu_resp_valid = lsu_valid_q;
    assign bus.lsu_resp_rdata = rdata_q;
    assign bus.lsu_resp_err   = err_q;

    // Memory side: payload always from the latches, only the enables are qualified.
    assign bus.mem_rd_en      = rd_en_q;
    assign bus.mem_rd_addr    = addr_q;
    assign bus.mem_we_en      = we_en_q;
    assign bus.mem_we_addr    = addr_q;
    assign bus.mem_we_data    = wdata_q;
    assign bus.mem_we_mask    = wmask_q;

endmodule

// File: tb/tb_dpic_mem_arbiter.sv
// Scoreboard bench for dpic_mem_arbiter (LATENCY = 2).
module tb_dpic_mem_arbiter;

    localparam int unsigned LAT = 2;

    typedef struct {
        logic [63:0] rdata;
        logic        err;
    } resp_t;

    typedef struct {
        logic [63:0] addr;
        logic [63:0] data;
        logic [7:0]  mask;
    } wr_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   cyc   = 0;

    int n_checks = 0;
    int n_fail   = 0;

    resp_t if_q[$];
    resp_t lsu_q[$];
    wr_t   we_q[$];
    logic  grant_q[$];

    int          acc_cyc      = 0;
    int          rd_cyc       = 0;
    int          we_cyc       = 0;
    int          if_resp_cyc  = 0;
    int          lsu_resp_cyc = 0;
    int          rd_cnt       = 0;
    int          we_cnt       = 0;
    logic [63:0] last_rd_addr = '0;

    logic        prev_if_v = 1'b0, prev_if_r = 1'b0;
    logic        prev_lsu_v = 1'b0, prev_lsu_r = 1'b0;
    logic [63:0] prev_if_d = '0, prev_lsu_d = '0;
    logic        prev_lsu_e = 1'b0;

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    dpic_mem_arbiter_if bus();

    dpic_mem_arbiter #(.LATENCY(LAT)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Memory contents: fixed word at the reset vector, address-derived elsewhere.
    function automatic logic [63:0] mem_word(input logic [63:0] a);
        if (a == 64'h8000_0000) return 64'hDEAD_BEEF_0000_1111;
        return {a[31:0] ^ 32'hA5A5_5A5A, ~a[31:0]};
    endfunction

    function automatic logic legal_mask(input logic [7:0] m);
        return (m == 8'h01) || (m == 8'h03) || (m == 8'h0F) || (m == 8'hFF);
    endfunction

    assign bus.mem_rd_data = mem_word(bus.mem_rd_addr);

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Monitor: grants, memory pulses, response hold and scoreboard pops.
    always @(negedge clock) begin
        if (!reset) begin
            prev_if_v  = 1'b0;
            prev_lsu_v = 1'b0;
        end else begin
            if (bus.if_req_ready && bus.lsu_req_ready) check("dual_ready", 64'(1), 64'(0));
            if ((bus.if_req_valid && bus.if_req_ready) || (bus.lsu_req_valid && bus.lsu_req_ready)) begin
                acc_cyc = cyc;
                if (grant_q.size() == 0) check("grant_unexpected", 64'(bus.lsu_req_ready), 64'(2));
                else check("grant_port", 64'(bus.lsu_req_ready), 64'(grant_q.pop_front()));
            end
            if (bus.mem_rd_en) begin
                rd_cnt++;
                rd_cyc       = cyc;
                last_rd_addr = bus.mem_rd_addr;
            end
            if (bus.mem_we_en) begin
                wr_t w;
                we_cnt++;
                we_cyc = cyc;
                if (we_q.size() == 0) check("we_unexpected", 64'(bus.mem_we_en), 64'(0));
                else begin
                    w = we_q.pop_front();
                    check("we_addr", bus.mem_we_addr, w.addr);
                    check("we_data", bus.mem_we_data, w.data);
                    check("we_mask", 64'(bus.mem_we_mask), 64'(w.mask));
                end
            end
            if (prev_if_v && !prev_if_r) begin
                check("if_hold_valid", 64'(bus.if_resp_valid), 64'(1));
                check("if_hold_rdata", bus.if_resp_rdata, prev_if_d);
            end
            if (prev_lsu_v && !prev_lsu_r) begin
                check("lsu_hold_valid", 64'(bus.lsu_resp_valid), 64'(1));
                check("lsu_hold_rdata", bus.lsu_resp_rdata, prev_lsu_d);
                check("lsu_hold_err", 64'(bus.lsu_resp_err), 64'(prev_lsu_e));
            end
            if (bus.if_resp_valid && !prev_if_v) if_resp_cyc = cyc;
            if (bus.lsu_resp_valid && !prev_lsu_v) lsu_resp_cyc = cyc;
            if (bus.if_resp_valid && bus.if_resp_ready) begin
                resp_t e;
                if (if_q.size() == 0) check("if_resp_unexpected", 64'(bus.if_resp_valid), 64'(0));
                else begin
                    e = if_q.pop_front();
                    check("if_rdata", bus.if_resp_rdata, e.rdata);
                end
            end
            if (bus.lsu_resp_valid && bus.lsu_resp_ready) begin
                resp_t e;
                if (lsu_q.size() == 0) check("lsu_resp_unexpected", 64'(bus.lsu_resp_valid), 64'(0));
                else begin
                    e = lsu_q.pop_front();
                    check("lsu_rdata", bus.lsu_resp_rdata, e.rdata);
                    check("lsu_err", 64'(bus.lsu_resp_err), 64'(e.err));
                end
            end
            prev_if_v  = bus.if_resp_valid;
            prev_if_r  = bus.if_resp_ready;
            prev_if_d  = bus.if_resp_rdata;
            prev_lsu_v = bus.lsu_resp_valid;
            prev_lsu_r = bus.lsu_resp_ready;
            prev_lsu_d = bus.lsu_resp_rdata;
            prev_lsu_e = bus.lsu_resp_err;
        end
    end

    task automatic issue_if(input logic [63:0] a);
        logic got = 1'b0;
        grant_q.push_back(1'b0);
        if_q.push_back('{rdata: mem_word(a), err: 1'b0});
        @(posedge clock); #1;
        bus.if_req_addr  = a;
        bus.if_req_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (bus.if_req_ready) begin got = 1'b1; break; end
        end
        check("if_accept", 64'(got), 64'(1));
        @(posedge clock); #1;
        bus.if_req_valid = 1'b0;
        bus.if_req_addr  = '0;
    endtask

    task automatic issue_lsu(input logic [63:0] a, input logic wen,
                             input logic [63:0] d, input logic [7:0] m);
        logic got = 1'b0;
        grant_q.push_back(1'b1);
        if (!wen) lsu_q.push_back('{rdata: mem_word(a), err: 1'b0});
        else if (legal_mask(m)) begin
            we_q.push_back('{addr: a, data: d, mask: m});
            lsu_q.push_back('{rdata: 64'h0, err: 1'b0});
        end else lsu_q.push_back('{rdata: 64'h0, err: 1'b1});
        @(posedge clock); #1;
        bus.lsu_req_addr  = a;
        bus.lsu_req_wen   = wen;
        bus.lsu_req_wdata = d;
        bus.lsu_req_wmask = m;
        bus.lsu_req_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (bus.lsu_req_ready) begin got = 1'b1; break; end
        end
        check("lsu_accept", 64'(got), 64'(1));
        @(posedge clock); #1;
        bus.lsu_req_valid = 1'b0;
        bus.lsu_req_wdata = 64'hFFFF_FFFF_FFFF_FFFF;
        bus.lsu_req_addr  = 64'hFFFF_FFFF_FFFF_FFFF;
        bus.lsu_req_wmask = 8'hFF;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200; i++) begin
            if (if_q.size() == 0 && lsu_q.size() == 0 && we_q.size() == 0) break;
            @(negedge clock);
        end
        check("drain", 64'(if_q.size() + lsu_q.size() + we_q.size()), 64'(0));
        @(posedge clock); #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rd_en"},   64'(bus.mem_rd_en), 64'(0));
        check({tag, "_we_en"},   64'(bus.mem_we_en), 64'(0));
        check({tag, "_we_addr"}, bus.mem_we_addr, 64'(0));
        check({tag, "_we_data"}, bus.mem_we_data, 64'(0));
        check({tag, "_we_mask"}, 64'(bus.mem_we_mask), 64'(0));
        check({tag, "_rd_addr"}, bus.mem_rd_addr, 64'(0));
        check({tag, "_if_rv"},   64'(bus.if_resp_valid), 64'(0));
        check({tag, "_lsu_rv"},  64'(bus.lsu_resp_valid), 64'(0));
        check({tag, "_lsu_err"}, 64'(bus.lsu_resp_err), 64'(0));
        check({tag, "_rdata"},   bus.if_resp_rdata, 64'(0));
        check({tag, "_if_rdy"},  64'(bus.if_req_ready), 64'(0));
        check({tag, "_lsu_rdy"}, 64'(bus.lsu_req_ready), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rd0, we0, n_acc;
        logic got;
        logic [63:0] if_a, lsu_a;

        bus.if_req_valid   = 1'b0;
        bus.if_req_addr    = '0;
        bus.if_resp_ready  = 1'b1;
        bus.lsu_req_valid  = 1'b0;
        bus.lsu_req_addr   = '0;
        bus.lsu_req_wen    = 1'b0;
        bus.lsu_req_wdata  = '0;
        bus.lsu_req_wmask  = '0;
        bus.lsu_resp_ready = 1'b1;

        // Reset state
        repeat (3) @(negedge clock);
        check_all_zero("reset");
        reset = 1'b1;

        // IF read with latency timing
        rd0 = rd_cnt;
        issue_if(64'h8000_0000);
        wait_idle();
        check("if_rd_pulses", 64'(rd_cnt - rd0), 64'(1));
        check("if_rd_addr", last_rd_addr, 64'h8000_0000);
        check("if_rd_latency", 64'(rd_cyc - acc_cyc), 64'(LAT));
        check("if_resp_latency", 64'(if_resp_cyc - acc_cyc), 64'(LAT + 1));

        // Legal LSU write: one pulse, response one cycle after it
        we0 = we_cnt;
        issue_lsu(64'h8000_0100, 1'b1, 64'h1122_3344, 8'h0F);
        wait_idle();
        check("wr_pulses", 64'(we_cnt - we0), 64'(1));
        check("wr_latency", 64'(we_cyc - acc_cyc), 64'(LAT));
        check("wr_resp_after_we", 64'(lsu_resp_cyc - we_cyc), 64'(1));

        // Illegal mask: no pulse, error response
        we0 = we_cnt;
        issue_lsu(64'h8000_0108, 1'b1, 64'h5555_6666, 8'h05);
        wait_idle();
        check("badmask_pulses", 64'(we_cnt - we0), 64'(0));

        // LSU read and byte write
        issue_lsu(64'h8000_0200, 1'b0, 64'h0, 8'h00);
        issue_lsu(64'h8000_0208, 1'b1, 64'hAB, 8'h01);
        wait_idle();

        // Both valids held: arbitration order over 4 accepts
        if_a  = 64'h8000_0040;
        lsu_a = 64'h8000_0300;
        for (int k = 0; k < 4; k++) begin
`ifdef DPIC_ARB_FIXED_PRIO_EN
            grant_q.push_back(1'b1);
            lsu_q.push_back('{rdata: mem_word(lsu_a), err: 1'b0});
`else
            grant_q.push_back(k[0]);
            if (k[0]) lsu_q.push_back('{rdata: mem_word(lsu_a), err: 1'b0});
            else      if_q.push_back('{rdata: mem_word(if_a), err: 1'b0});
`endif
        end
        @(posedge clock); #1;
        bus.if_req_addr   = if_a;
        bus.lsu_req_addr  = lsu_a;
        bus.lsu_req_wen   = 1'b0;
        bus.if_req_valid  = 1'b1;
        bus.lsu_req_valid = 1'b1;
        n_acc = 0;
        for (int i = 0; i < 200 && n_acc < 4; i++) begin
            @(negedge clock);
            if (bus.if_req_ready || bus.lsu_req_ready) n_acc++;
        end
        check("both_valid_accepts", 64'(n_acc), 64'(4));
        @(posedge clock); #1;
        bus.if_req_valid  = 1'b0;
        bus.lsu_req_valid = 1'b0;
        wait_idle();
        check("both_valid_grants_left", 64'(grant_q.size()), 64'(0));

        // IF response back-pressure while LSU waits
        bus.if_resp_ready = 1'b0;
        issue_if(64'h8000_0080);
        grant_q.push_back(1'b1);
        lsu_q.push_back('{rdata: mem_word(64'h8000_0400), err: 1'b0});
        bus.lsu_req_addr  = 64'h8000_0400;
        bus.lsu_req_wen   = 1'b0;
        bus.lsu_req_valid = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            if (bus.if_resp_valid) begin got = 1'b1; break; end
        end
        check("bp_resp_seen", 64'(got), 64'(1));
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check("bp_lsu_blocked", 64'(bus.lsu_req_ready), 64'(0));
            check("bp_if_valid", 64'(bus.if_resp_valid), 64'(1));
            check("bp_if_rdata", bus.if_resp_rdata, mem_word(64'h8000_0080));
        end
        @(posedge clock); #1;
        bus.if_resp_ready = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            if (bus.lsu_req_ready) begin got = 1'b1; break; end
        end
        check("bp_lsu_accept", 64'(got), 64'(1));
        @(posedge clock); #1;
        bus.lsu_req_valid = 1'b0;
        wait_idle();

        // Reset during BUSY of a write: transaction discarded, no pulse
        we0 = we_cnt;
        grant_q.push_back(1'b1);
        @(posedge clock); #1;
        bus.lsu_req_addr  = 64'h8000_0500;
        bus.lsu_req_wen   = 1'b1;
        bus.lsu_req_wdata = 64'hCAFE_F00D;
        bus.lsu_req_wmask = 8'hFF;
        bus.lsu_req_valid = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            if (bus.lsu_req_ready) begin got = 1'b1; break; end
        end
        check("rst_wr_accept", 64'(got), 64'(1));
        @(posedge clock); #1;
        bus.lsu_req_valid = 1'b0;
        bus.lsu_req_wen   = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check_all_zero("midreset");
        repeat (4) @(negedge clock);
        check("midreset_no_pulse", 64'(we_cnt - we0), 64'(0));
        reset = 1'b1;
        repeat (2) @(negedge clock);
        check("post_reset_no_pulse", 64'(we_cnt - we0), 64'(0));

        // Normal IF read after reset
        rd0 = rd_cnt;
        issue_if(64'h8000_0010);
        wait_idle();
        check("post_rst_rd_pulses", 64'(rd_cnt - rd0), 64'(1));
        check("post_rst_rd_latency", 64'(rd_cyc - acc_cyc), 64'(LAT));
        check("post_rst_resp_latency", 64'(if_resp_cyc - acc_cyc), 64'(LAT + 1));
        check("grant_q_empty", 64'(grant_q.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dpic_mem_arbiter.md
# dpic_mem_arbiter

Two-requester arbiter and sequencer in front of the single DPI-C simulation memory port (`dpic_memory`). It shares the memory between the instruction-fetch (IF) read port and the load/store (LSU) read/write port, and emulates a configurable memory latency. It also guarantees that each write reaches the DPI-C memory as a single-cycle pulse with stable address, data and mask. It sits between the core's IF/LSU stages and `dpic_memory` in the NPC simulation top.

## Interface
- `LATENCY`, default 2: wait cycles between accept and memory access; legal range 1..15.
- `clock`  in  1  sole clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `if_req_valid` in 1 / `if_req_ready` out 1 / `if_req_addr` in 64: IF read request.
- `if_resp_valid` out 1 / `if_resp_ready` in 1 / `if_resp_rdata` out 64: IF response.
- `lsu_req_valid` in 1 / `lsu_req_ready` out 1 / `lsu_req_addr` in 64: LSU request.
- `lsu_req_wen` in 1 / `lsu_req_wdata` in 64 / `lsu_req_wmask` in 8: 1 = write.
- `lsu_resp_valid` out 1 / `lsu_resp_ready` in 1 / `lsu_resp_rdata` out 64 / `lsu_resp_err` out 1: LSU response. Error is set for an illegal write mask.
- `mem_rd_en` out 1 / `mem_rd_addr` out 64 / `mem_rd_data` in 64: to the memory read port.
- `mem_we_en` out 1 / `mem_we_addr` out 64 / `mem_we_data` out 64 / `mem_we_mask` out 8: to the memory write port.

## Operation
- FSM states:
  - IDLE: accepts a request. On accept, go to BUSY.
  - BUSY: a 4-bit counter loads `LATENCY-1` on accept and decrements each cycle. When the counter is 0, issue the memory access and go to RESP.
  - RESP: the granted port's `*_resp_valid` is 1. Hold until the matching `*_resp_ready` is sampled high, then go to IDLE.
- Grant is combinational in IDLE only:
  - `*_req_ready` is 1 for the granted port and only when that port's valid is high. It is never 1 for both ports, and it is 0 in BUSY/RESP.
- Arbitration is round-robin:
  - A 1-bit pointer names the preferred port.
  - On every accept, the pointer moves to the port not granted.
  - A lone valid requester always wins.
- On accept, latch port id, addr, wen, wdata and wmask. Requester inputs are don't-care afterwards.
- Read access, on the final BUSY cycle:
  - `mem_rd_en`=1 and `mem_rd_addr`=latched addr.
  - `mem_rd_data` is registered into the response rdata at that edge.
- Write access, on the final BUSY cycle:
  - `mem_we_en`=1 for exactly one cycle, with latched addr/data/mask on the `mem_we_*` outputs.
  - Response rdata = 0, err = 0.
- Legal write masks are 0x01, 0x03, 0x0F and 0xFF.
  - Any other mask: no `mem_we_en` pulse, and `lsu_resp_err`=1 in RESP.
- IF requests are reads only. `mem_we_en` is never asserted for port 0.
- `mem_*` address/data/mask outputs are driven from the latch registers at all times. Only the enables are qualified.

## Timing
- Accept at edge T. The access occurs in the cycle ending at edge T+LATENCY. `*_resp_valid` rises after edge T+LATENCY and is visible during cycle T+LATENCY+1.
- `*_resp_valid` and `*_resp_rdata`/`*_resp_err` stay stable until the handshake completes.
- Handshake in cycle N: the FSM is IDLE in cycle N+1, where a new accept may occur. Minimum spacing between accepts is LATENCY+2 cycles.
- Reset (asynchronous, active-low):
  - FSM goes to IDLE, counter to 0, pointer to IF.
  - All latches and every output go to 0, including `mem_rd_en` and `mem_we_en`.
  - An in-flight transaction is discarded and no write pulse is emitted.
- Simultaneous valids in IDLE are resolved by the pointer. The loser's valid stays pending and it is granted on the next IDLE cycle.
- A response-ready asserted while the port's resp_valid is 0 is ignored.

## Configuration
- `DPIC_ARB_FIXED_PRIO_EN` defined:
  - The LSU always wins when both valids are high, and the pointer is unused.
  - IF is granted only when `lsu_req_valid`=0.
- Undefined: round-robin as described above.

## Test plan
- IF read, LATENCY=2, addr 0x8000_0000, memory word 0xDEAD_BEEF_0000_1111:
  - `if_req_ready` at T and `mem_rd_en` one cycle at T+2.
  - `if_resp_valid` with rdata 0xDEAD_BEEF_0000_1111 in cycle T+3.
- LSU write, addr 0x8000_0100, data 0x1122_3344, mask 0x0F:
  - Exactly one `mem_we_en` cycle carrying those values.
  - `lsu_resp_valid` with err=0 one cycle later.
- LSU write with mask 0x05:
  - `mem_we_en` never asserts.
  - `lsu_resp_err`=1 with rdata 0.
- Both valids held high for 4 transactions:
  - Grants go IF, LSU, IF, LSU.
  - With `DPIC_ARB_FIXED_PRIO_EN`, all 4 go to the LSU.
- `if_resp_ready` low for 5 cycles in RESP:
  - resp_valid/rdata hold steady.
  - `lsu_req_ready` stays 0 despite `lsu_req_valid`=1.
- `reset` pulsed low during BUSY of a write:
  - All outputs 0 immediately and no `mem_we_en` pulse.
  - The next IF read completes with normal latency.
